// File: rtl/bsg_mesh_traffic_gen.sv
// bsg_mesh_traffic_gen
//
// Packet injector for one router's local (P) input port in the bsg mesh NoC.
// It produces a programmed burst of coordinate-addressed packets. Each
// packet is presented under a valid/yumi handshake.
//
// Packet layout, MSB to LSB: {src_y, src_x, payload, dest_y, dest_x}.
// A node index is {y, x}. The source field lets the receiving checker
// attribute each packet to the node that sent it.
//
// Handshake (valid/yumi):
//   v_o is asserted while a packet is offered, and data_o holds that packet.
//   The router pulses yumi_i in any cycle where it consumes the packet. The
//   packet is taken on that clock edge. v_o never drops, and data_o never
//   changes, until that yumi. yumi_i has no effect while v_o is low.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   my_x_i, my_y_i       this node's coordinate (latched on start)
//   start_i              begin a burst (only looked at in IDLE)
//   num_pkts_i           number of packets in the burst (0 = empty burst)
//   gap_i                idle cycles inserted between packets
//   dest_mode_i          0 = fixed destination, 1 = round-robin over other nodes
//   fixed_x_i, fixed_y_i fixed-mode destination
//   payload_mode_i       0 = sequence number, 1 = LFSR data
//   v_o, data_o, yumi_i  packet handshake toward the router
//   busy_o               burst in progress (SEND or GAP)
//   done_o               one-cycle pulse when a burst finishes
//   sent_count_o         packets accepted in the current/last burst
module bsg_mesh_traffic_gen #(
  parameter int x_cord_width_p = 1,
  parameter int y_cord_width_p = 1,
  parameter int data_width_p   = 4,
  parameter int count_width_p  = 8,
  parameter int gap_width_p    = 4,
  parameter logic [data_width_p-1:0] lfsr_poly_p = 4'b1100,
  parameter logic [data_width_p-1:0] lfsr_seed_p = 4'b0001
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [x_cord_width_p-1:0]                              my_x_i,
  input  logic [y_cord_width_p-1:0]                              my_y_i,
  input  logic                                                   start_i,
  input  logic [count_width_p-1:0]                               num_pkts_i,
  input  logic [gap_width_p-1:0]                                 gap_i,
  input  logic                                                   dest_mode_i,
  input  logic [x_cord_width_p-1:0]                              fixed_x_i,
  input  logic [y_cord_width_p-1:0]                              fixed_y_i,
  input  logic                                                   payload_mode_i,
  output logic                                                   v_o,
  output logic [2*(x_cord_width_p+y_cord_width_p)+data_width_p-1:0] data_o,
  input  logic                                                   yumi_i,
  output logic                                                   busy_o,
  output logic                                                   done_o,
  output logic [count_width_p-1:0]                               sent_count_o
);

  localparam int cord_w = x_cord_width_p + y_cord_width_p;
  localparam int pkt_w  = 2 * cord_w + data_width_p;

  localparam logic [cord_w-1:0]        cord_one  = cord_w'(1);
  localparam logic [count_width_p-1:0] count_one = count_width_p'(1);
  localparam logic [gap_width_p-1:0]   gap_one   = gap_width_p'(1);
  localparam logic [data_width_p-1:0]  data_one  = data_width_p'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q;

  // Burst configuration captured when a start is accepted
  logic [count_width_p-1:0] num_q;
  logic [gap_width_p-1:0]   gap_q;
  logic                     dmode_q;
  logic                     pmode_q;
  logic [cord_w-1:0]        fixed_q;
  logic [cord_w-1:0]        self_q;

  // Per-packet generators
  logic [data_width_p-1:0]  seq_q;
  logic [data_width_p-1:0]  lfsr_q;
  logic [cord_w-1:0]        rr_q;
  logic [gap_width_p-1:0]   gap_cnt_q;

  // Registered outputs
  logic                     v_q;
  logic [pkt_w-1:0]         data_q;
  logic                     done_q;
  logic [count_width_p-1:0] sent_q;

  function automatic logic [pkt_w-1:0] pack_pkt(
    input logic [cord_w-1:0]       src,
    input logic [data_width_p-1:0] payload,
    input logic [cord_w-1:0]       dest
  );
    return {src, payload, dest};
  endfunction

  // Start-time view of the inputs
  logic [cord_w-1:0]       self_in;
  logic [cord_w-1:0]       fixed_in;
  logic [cord_w-1:0]       rr_first;
  logic [data_width_p-1:0] first_payload;
  logic [cord_w-1:0]       first_dest;

  // Next-packet view, used when the current packet is consumed
  logic [data_width_p-1:0]  lfsr_step;
  logic [cord_w-1:0]        rr_inc;
  logic [cord_w-1:0]        rr_next;
  logic [data_width_p-1:0]  next_payload;
  logic [cord_w-1:0]        next_dest;
  logic [count_width_p-1:0] sent_inc;
  logic                     last_pkt;

  always_comb begin
    self_in       = {my_y_i, my_x_i};
    fixed_in      = {fixed_y_i, fixed_x_i};
    // N >= 4 because both coordinate widths are at least 1.
    // So self+1 never lands back on self.
    rr_first      = self_in + cord_one;
    first_payload = payload_mode_i ? lfsr_q : '0;
    first_dest    = dest_mode_i ? rr_first : fixed_in;

    // Galois step: shift right, and fold in the polynomial when the bit shifted out is 1
    lfsr_step     = (lfsr_q >> 1) ^ (lfsr_q[0] ? lfsr_poly_p : '0);

    // Round-robin advance that never addresses this node
    rr_inc        = rr_q + cord_one;
    rr_next       = (rr_inc == self_q) ? (rr_inc + cord_one) : rr_inc;

    next_payload  = pmode_q ? lfsr_step : (seq_q + data_one);
    next_dest     = dmode_q ? rr_next : fixed_q;

    sent_inc      = sent_q + count_one;
    last_pkt      = (sent_inc == num_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      gap_q     <= '0;
      dmode_q   <= 1'b0;
      pmode_q   <= 1'b0;
      fixed_q   <= '0;
      self_q    <= '0;
      seq_q     <= '0;
      lfsr_q    <= lfsr_seed_p;
      rr_q      <= '0;
      gap_cnt_q <= '0;
      v_q       <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      sent_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            num_q   <= num_pkts_i;
            gap_q   <= gap_i;
            dmode_q <= dest_mode_i;
            pmode_q <= payload_mode_i;
            fixed_q <= fixed_in;
            self_q  <= self_in;
            sent_q  <= '0;
            seq_q   <= '0;
            rr_q    <= rr_first;
            if (num_pkts_i != '0) begin
              state_q <= S_SEND;
              v_q     <= 1'b1;
              data_q  <= pack_pkt(self_in, first_payload, first_dest);
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        S_SEND: begin
          if (yumi_i) begin
            sent_q <= sent_inc;
            seq_q  <= seq_q + data_one;
            rr_q   <= rr_next;
            // Sequence-mode bursts leave the LFSR alone.
            // An LFSR stream therefore continues across bursts.
            if (pmode_q) lfsr_q <= lfsr_step;
            if (last_pkt) begin
              state_q <= S_DONE;
              v_q     <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              data_q <= pack_pkt(self_q, next_payload, next_dest);
              if (gap_q != '0) begin
                state_q   <= S_GAP;
                v_q       <= 1'b0;
                gap_cnt_q <= gap_q;
              end
            end
          end
        end

        S_GAP: begin
          // Leaving when the count reaches 1 gives exactly gap_q idle cycles
          gap_cnt_q <= gap_cnt_q - gap_one;
          if (gap_cnt_q == gap_one) begin
            state_q <= S_SEND;
            v_q     <= 1'b1;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          v_q     <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign v_o          = v_q;
  assign data_o       = data_q;
  assign done_o       = done_q;
  assign sent_count_o = sent_q;
  assign busy_o       = (state_q == S_SEND) || (state_q == S_GAP);

endmodule

// File: tb/tb_bsg_mesh_traffic_gen.sv
// Bench for bsg_mesh_traffic_gen with default parameters: 1-bit coordinates,
// 4-bit payload, 8-bit packets laid out as {src_y, src_x, payload, dest_y, dest_x}.
// Burst vectors hold hand-computed packet bytes. Multi-cycle corner cases are
// written out as explicit sequences.
module tb_bsg_mesh_traffic_gen;

  logic       clk;
  logic       reset;
  logic       my_x, my_y;
  logic       start;
  logic [7:0] num_pkts;
  logic [3:0] gap;
  logic       dest_mode;
  logic       fixed_x, fixed_y;
  logic       payload_mode;
  logic       v;
  logic [7:0] data;
  logic       yumi;
  logic       busy;
  logic       done;
  logic [7:0] sent_count;

  int total = 0;
  int bad   = 0;

  bsg_mesh_traffic_gen dut (
    .clk            (clk),
    .reset          (reset),
    .my_x_i         (my_x),
    .my_y_i         (my_y),
    .start_i        (start),
    .num_pkts_i     (num_pkts),
    .gap_i          (gap),
    .dest_mode_i    (dest_mode),
    .fixed_x_i      (fixed_x),
    .fixed_y_i      (fixed_y),
    .payload_mode_i (payload_mode),
    .v_o            (v),
    .data_o         (data),
    .yumi_i         (yumi),
    .busy_o         (busy),
    .done_o         (done),
    .sent_count_o   (sent_count)
  );

  // Clock: 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            dmode;
    logic            pmode;
    logic [3:0]      gap;
    logic [7:0]      num;
    logic            fx;
    logic            fy;
    logic            mx;
    logic            my;
    logic [3:0][7:0] exp;   // exp[0] = first packet
  } burst_t;

  burst_t vec [7];

  function automatic burst_t mk(input logic dm, input logic pm, input logic [3:0] g,
                                input logic [7:0] n, input logic fx, input logic fy,
                                input logic mx, input logic my,
                                input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
    burst_t b;
    b.dmode = dm; b.pmode = pm; b.gap = g; b.num = n;
    b.fx = fx; b.fy = fy; b.mx = mx; b.my = my;
    b.exp[0] = e0; b.exp[1] = e1; b.exp[2] = e2; b.exp[3] = e3;
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_cfg(input burst_t b);
    dest_mode    = b.dmode;
    payload_mode = b.pmode;
    gap          = b.gap;
    num_pkts     = b.num;
    fixed_x      = b.fx;
    fixed_y      = b.fy;
    my_x         = b.mx;
    my_y         = b.my;
  endtask

  // Runs one burst with yumi held high and checks every cycle from start to done.
  // The caller is at a negedge.
  task automatic run_burst(input int idx, input burst_t b);
    set_cfg(b);
    yumi  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < int'(b.num); k++) begin
      if (k > 0) begin
        for (int g = 0; g < int'(b.gap); g++) begin
          chk($sformatf("v%0d_gap_v", idx), v, 0);
          chk($sformatf("v%0d_gap_busy", idx), busy, 1);
          @(negedge clk);
        end
      end
      chk($sformatf("v%0d_pkt%0d_v", idx, k), v, 1);
      chk($sformatf("v%0d_pkt%0d_busy", idx, k), busy, 1);
      chk($sformatf("v%0d_pkt%0d_cnt", idx, k), sent_count, k);
      if (k < 4) chk($sformatf("v%0d_pkt%0d_data", idx, k), data, b.exp[k]);
      @(negedge clk);
    end
    chk($sformatf("v%0d_done", idx), done, 1);
    chk($sformatf("v%0d_done_v", idx), v, 0);
    chk($sformatf("v%0d_done_busy", idx), busy, 0);
    chk($sformatf("v%0d_final_cnt", idx), sent_count, b.num);
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", idx), done, 0);
    chk($sformatf("v%0d_idle_v", idx), v, 0);
  endtask

  initial begin
    // LFSR bursts come first so the LFSR starts from its seed (0001)
    //             dm  pm gap   num  fx fy mx my   packets
    vec[0] = mk(1'b0, 1'b1, 4'd0, 8'd4,   1, 0, 0, 1, 8'h85, 8'hB1, 8'h99, 8'h8D);
    vec[1] = mk(1'b0, 1'b1, 4'd0, 8'd2,   1, 0, 0, 1, 8'hB5, 8'hA9, 8'h00, 8'h00);
    vec[2] = mk(1'b0, 1'b0, 4'd0, 8'd3,   1, 1, 0, 0, 8'h03, 8'h07, 8'h0B, 8'h00);
    vec[3] = mk(1'b1, 1'b0, 4'd0, 8'd4,   0, 0, 1, 0, 8'h42, 8'h47, 8'h48, 8'h4E);
    vec[4] = mk(1'b0, 1'b0, 4'd2, 8'd3,   0, 1, 1, 1, 8'hC2, 8'hC6, 8'hCA, 8'h00);
    vec[5] = mk(1'b1, 1'b0, 4'd1, 8'd3,   0, 0, 1, 1, 8'hC0, 8'hC5, 8'hCA, 8'h00);
    vec[6] = mk(1'b0, 1'b0, 4'd0, 8'd255, 1, 1, 0, 0, 8'h03, 8'h07, 8'h0B, 8'h0F);

    reset = 1'b1; start = 1'b0; yumi = 1'b0;
    my_x = 0; my_y = 0; num_pkts = 0; gap = 0; dest_mode = 0;
    fixed_x = 0; fixed_y = 0; payload_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_v", v, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", sent_count, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_yumi_ignored_cnt", sent_count, 0);
    chk("idle_v", v, 0);

    for (int i = 0; i < 7; i++) run_burst(i, vec[i]);

    // Empty burst: done pulses and no packet is offered
    num_pkts = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_v", v, 0);
    chk("zero_busy", busy, 0);
    chk("zero_cnt", sent_count, 0);
    @(negedge clk);
    chk("zero_done_pulse", done, 0);
    chk("zero_v_after", v, 0);

    // Backpressure: packet held stable while the router stalls
    set_cfg(mk(1'b0, 1'b0, 4'd0, 8'd2, 1, 1, 0, 0, 8'h03, 8'h07, 8'h00, 8'h00));
    yumi = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int s = 0; s < 5; s++) begin
      chk("bp_stall0_v", v, 1);
      chk("bp_stall0_data", data, 8'h03);
      chk("bp_stall0_cnt", sent_count, 0);
      @(negedge clk);
    end
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
    chk("bp_pkt1_v", v, 1);
    chk("bp_pkt1_data", data, 8'h07);
    chk("bp_pkt1_cnt", sent_count, 1);
    @(negedge clk);
    chk("bp_stall1_v", v, 1);
    chk("bp_stall1_data", data, 8'h07);
    chk("bp_stall1_cnt", sent_count, 1);
    yumi = 1'b1;
    @(negedge clk);
    chk("bp_done", done, 1);
    chk("bp_final_cnt", sent_count, 2);
    chk("bp_done_v", v, 0);
    @(negedge clk);

    // Reset mid-SEND, with start and yumi also high in the reset cycle
    set_cfg(mk(1'b0, 1'b0, 4'd0, 8'd5, 1, 1, 0, 0, 8'h03, 8'h07, 8'h00, 8'h00));
    yumi = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rm_pkt0_data", data, 8'h03);
    @(negedge clk);
    chk("rm_pkt1_data", data, 8'h07);
    chk("rm_pkt1_cnt", sent_count, 1);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rm_v", v, 0);
    chk("rm_busy", busy, 0);
    chk("rm_cnt", sent_count, 0);
    chk("rm_data", data, 0);
    chk("rm_done", done, 0);
    @(negedge clk);
    chk("rm_no_start_v", v, 0);
    chk("rm_no_start_busy", busy, 0);
    chk("rm_no_start_done", done, 0);
    yumi = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
